// File: rtl/pe_pkg.sv
// Shared definitions for the vector PE engine: opcodes, instruction
// field positions and the FSM state type.
package pe_pkg;

    localparam logic [3:0] OP_MAC  = 4'h1;
    localparam logic [3:0] OP_RELU = 4'h2;
    localparam logic [3:0] OP_PASS = 4'h3;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 28;
    localparam int LAST_BIT   = 27;
    localparam int SHIFT_MSB  = 12;
    localparam int SHIFT_LSB  = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

endpackage

// File: rtl/pe_out_fifo.sv
// Result FIFO. Head data is forced to zero while empty so the output
// bus is clean during and after reset.
module pe_out_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] head_data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Readiness comes from the pre-edge count only, so a full FIFO blocks
    // a push even when a pop happens on the same edge.
    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0);
    assign do_push   = push && in_ready;
    assign do_pop    = out_valid && out_ready;
    assign head_data = out_valid ? mem[rd_ptr] : '0;

    // Storage write; contents need no reset because head_data is gated by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy bookkeeping with modulo-DEPTH wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pe_vec_engine.sv
// Vector processing element: per-lane signed MAC with a shared IDLE/ACC
// sequencer, ReLU and pass-through ops, and a small result FIFO.
//
// Handshake: a beat transfers on a rising edge where valid_in && ready_out;
// ready_out never depends on valid_in. A result leaves on an edge where
// valid_out && ready_in, and result_packed is held while it waits.
module pe_vec_engine
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 8,
    parameter int ACC_WIDTH  = 40,
    parameter int OUT_DEPTH  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_in,
    output logic                        ready_out,
    input  logic [31:0]                 instruction,
    input  logic [DATA_WIDTH*LANES-1:0] data_a_packed,
    input  logic [DATA_WIDTH*LANES-1:0] weight_packed,
    output logic [DATA_WIDTH*LANES-1:0] result_packed,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic                        busy_o,
    output logic                        err_o
);

    localparam int VW = DATA_WIDTH * LANES;

    state_t        state_q;
    state_t        state_d;
    logic          err_q;
    logic [3:0]    opcode;
    logic          is_last;
    logic [4:0]    shamt;
    logic          is_mac;
    logic          is_relu;
    logic          is_pass;
    logic          accept;
    logic          push;
    logic          proto_err;
    logic [VW-1:0] push_data;
    logic          unused_instr;

    assign opcode       = instruction[OPCODE_MSB:OPCODE_LSB];
    assign is_last      = instruction[LAST_BIT];
    assign shamt        = instruction[SHIFT_MSB:SHIFT_LSB];
    assign unused_instr = ^{instruction[26:13], instruction[7:0]};

    assign is_mac  = (opcode == OP_MAC);
    assign is_relu = (opcode == OP_RELU);
    assign is_pass = (opcode == OP_PASS);

    assign accept    = valid_in && ready_out;
    assign push      = accept && ((is_mac && is_last) || is_relu || is_pass);
    // Unknown opcodes, or a non-MAC op arriving mid-accumulation, are protocol errors.
    assign proto_err = accept && (!(is_mac || is_relu || is_pass) ||
                                  ((is_relu || is_pass) && (state_q == ST_ACC)));

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state: only a non-final MAC keeps (or enters) accumulation.
    always_comb begin
        state_d = state_q;
        if (accept) state_d = (is_mac && !is_last) ? ST_ACC : ST_IDLE;
    end

    // Sequencer outputs.
    always_comb begin
        busy_o = (state_q == ST_ACC);
    end

    // Sticky protocol error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            err_q <= 1'b0;
        else if (proto_err) err_q <= 1'b1;
    end

    assign err_o = err_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [DATA_WIDTH-1:0]   a_i;
        logic signed [DATA_WIDTH-1:0]   w_i;
        logic signed [2*DATA_WIDTH-1:0] prod;
        logic signed [ACC_WIDTH-1:0]    acc_q;
        logic signed [ACC_WIDTH-1:0]    base;
        logic signed [ACC_WIDTH-1:0]    sum;
        logic signed [ACC_WIDTH-1:0]    shifted;
        logic                           fits;
        logic [DATA_WIDTH-1:0]          mac_res;
        logic [DATA_WIDTH-1:0]          relu_res;
        logic [DATA_WIDTH-1:0]          lane_res;

        assign a_i  = data_a_packed[i*DATA_WIDTH +: DATA_WIDTH];
        assign w_i  = weight_packed[i*DATA_WIDTH +: DATA_WIDTH];
        assign prod = a_i * w_i;
        // A fresh accumulation starts from zero; the sum wraps at ACC_WIDTH.
        assign base    = (state_q == ST_ACC) ? acc_q : '0;
        assign sum     = base + ACC_WIDTH'(prod);
        assign shifted = sum >>> shamt;
        // Fits when every bit above the output sign bit matches the sign.
        assign fits    = (shifted[ACC_WIDTH-1:DATA_WIDTH-1] ==
                          {(ACC_WIDTH-DATA_WIDTH+1){shifted[ACC_WIDTH-1]}});
        assign mac_res  = fits ? shifted[DATA_WIDTH-1:0]
                               : {shifted[ACC_WIDTH-1], {(DATA_WIDTH-1){~shifted[ACC_WIDTH-1]}}};
        assign relu_res = a_i[DATA_WIDTH-1] ? '0 : a_i;

        // Lane result select by opcode.
        always_comb begin
            lane_res = a_i;
            if (is_mac)       lane_res = mac_res;
            else if (is_relu) lane_res = relu_res;
        end

        assign push_data[i*DATA_WIDTH +: DATA_WIDTH] = lane_res;

        // Lane accumulator: keeps the sum only on a non-final MAC, else clears.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)         acc_q <= '0;
            else if (accept) acc_q <= (is_mac && !is_last) ? sum : '0;
        end
    end

    pe_out_fifo #(
        .WIDTH (VW),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .in_ready  (ready_out),
        .out_valid (valid_out),
        .out_ready (ready_in),
        .head_data (result_packed)
    );

endmodule

// File: tb/tb_pe_vec_engine.sv
// Bench for pe_vec_engine: directed scenarios followed by randomized beats,
// checked against a lane-array / queue reference model.
module tb_pe_vec_engine;

    localparam int DW = 16;
    localparam int LN = 8;
    localparam int AW = 40;
    localparam int OD = 2;
    localparam int VW = DW * LN;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic          ready_out;
    logic [31:0]   instruction;
    logic [VW-1:0] data_a_packed;
    logic [VW-1:0] weight_packed;
    logic [VW-1:0] result_packed;
    logic          valid_out;
    logic          ready_in;
    logic          busy_o;
    logic          err_o;

    logic signed [DW-1:0] a_l [LN];
    logic signed [DW-1:0] w_l [LN];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [VW-1:0] exp_q [$];
    longint        m_acc [LN];
    bit            m_in_acc;
    bit            m_err;
    bit            m_accepted;

    always #5 clk = ~clk;

    pe_vec_engine #(
        .DATA_WIDTH (DW),
        .LANES      (LN),
        .ACC_WIDTH  (AW),
        .OUT_DEPTH  (OD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .instruction   (instruction),
        .data_a_packed (data_a_packed),
        .weight_packed (weight_packed),
        .result_packed (result_packed),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    always_comb begin
        data_a_packed = '0;
        weight_packed = '0;
        for (int i = 0; i < LN; i++) begin
            data_a_packed[i*DW +: DW] = a_l[i];
            weight_packed[i*DW +: DW] = w_l[i];
        end
    end

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint wrap_acc(input longint v);
        longint t;
        t = v <<< (64 - AW);
        return t >>> (64 - AW);
    endfunction

    function automatic logic [DW-1:0] sat_dw(input longint v);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (DW - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return DW'(hi);
        if (v < lo) return DW'(lo);
        return DW'(v);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < LN; i++) m_acc[i] = 0;
        m_in_acc = 0;
        m_err    = 0;
    endtask

    // Apply the effect of an accepted beat to the model.
    task automatic model_beat(input logic [31:0] ins);
        logic [3:0]    op;
        bit            last;
        int            sh;
        logic [VW-1:0] res;
        bit            pushes;
        longint        s;
        op     = ins[31:28];
        last   = ins[27];
        sh     = int'(ins[12:8]);
        res    = '0;
        pushes = 0;
        case (op)
            4'h1: begin
                for (int i = 0; i < LN; i++) begin
                    s = wrap_acc((m_in_acc ? m_acc[i] : 0) + longint'(a_l[i]) * longint'(w_l[i]));
                    if (last) begin
                        res[i*DW +: DW] = sat_dw(s >>> sh);
                        m_acc[i] = 0;
                    end else begin
                        m_acc[i] = s;
                    end
                end
                pushes   = last;
                m_in_acc = !last;
            end
            4'h2, 4'h3: begin
                if (m_in_acc) m_err = 1;
                for (int i = 0; i < LN; i++) begin
                    m_acc[i] = 0;
                    res[i*DW +: DW] = (op == 4'h2 && a_l[i] < 0) ? '0 : a_l[i];
                end
                m_in_acc = 0;
                pushes   = 1;
            end
            default: begin
                m_err = 1;
                for (int i = 0; i < LN; i++) m_acc[i] = 0;
                m_in_acc = 0;
            end
        endcase
        if (pushes) exp_q.push_back(res);
    endtask

    // One clock: pre-edge handshake/head checks, edge, model update, post-edge status checks.
    task automatic step(input string tag);
        bit pop_m;
        bit room;
        room  = (exp_q.size() != OD);
        check({tag, " ready_out"}, VW'(ready_out), VW'(room));
        check({tag, " valid_out"}, VW'(valid_out), VW'(exp_q.size() != 0));
        if (exp_q.size() != 0) check({tag, " result"}, result_packed, exp_q[0]);
        m_accepted = valid_in && room;
        pop_m      = (exp_q.size() != 0) && ready_in;
        @(posedge clk);
        #1;
        if (pop_m) void'(exp_q.pop_front());
        if (m_accepted) model_beat(instruction);
        check({tag, " busy_o"}, VW'(busy_o), VW'(m_in_acc));
        check({tag, " err_o"}, VW'(err_o), VW'(m_err));
    endtask

    task automatic set_all(input int a, input int w);
        for (int i = 0; i < LN; i++) begin
            a_l[i] = DW'(a);
            w_l[i] = DW'(w);
        end
    endtask

    task automatic send(input logic [3:0] op, input bit last, input int sh, input string tag);
        instruction = {op, last, 14'b0, 5'(sh), 8'b0};
        valid_in    = 1'b1;
        m_accepted  = 0;
        for (int n = 0; n < 20; n++) begin
            step(tag);
            if (m_accepted) break;
        end
        checks++;
        assert (m_accepted) else begin
            errors++;
            $error("FAIL %s accept: observed no transfer in 20 cycles, expected transfer", tag);
        end
        valid_in = 1'b0;
    endtask

    logic [VW-1:0] pat;

    initial begin
        rst         = 1'b1;
        valid_in    = 1'b0;
        ready_in    = 1'b1;
        instruction = '0;
        set_all(0, 0);
        model_reset();
        #1;
        check("reset ready_out", VW'(ready_out), VW'(1));
        check("reset valid_out", VW'(valid_out), VW'(0));
        check("reset busy_o", VW'(busy_o), VW'(0));
        check("reset err_o", VW'(err_o), VW'(0));
        check("reset result", result_packed, '0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Three-beat MAC, 2*3 per beat -> 18 per lane
        set_all(2, 3);
        send(4'h1, 0, 0, "mac3 b1");
        send(4'h1, 0, 0, "mac3 b2");
        send(4'h1, 1, 0, "mac3 b3");
        check("mac3 valid", VW'(valid_out), VW'(1));
        check("mac3 value", result_packed, {LN{16'd18}});
        step("mac3 drain");

        // Saturation and shift corners
        set_all(32767, 32767);
        send(4'h1, 1, 0, "sat pos");
        check("sat pos value", result_packed, {LN{16'h7fff}});
        step("sat pos drain");
        set_all(-32768, 32767);
        send(4'h1, 1, 0, "sat neg");
        check("sat neg value", result_packed, {LN{16'h8000}});
        step("sat neg drain");
        set_all(32767, 32767);
        send(4'h1, 1, 15, "shift15");
        check("shift15 value", result_packed, {LN{16'h7ffe}});
        step("shift15 drain");

        // Backpressure: third PASS is held until the FIFO drains
        ready_in = 1'b0;
        set_all(1, 0);
        send(4'h3, 0, 0, "bp pass1");
        set_all(2, 0);
        send(4'h3, 0, 0, "bp pass2");
        check("bp full ready_out", VW'(ready_out), VW'(0));
        set_all(3, 0);
        instruction = {4'h3, 28'b0};
        valid_in    = 1'b1;
        step("bp held1");
        step("bp held2");
        check("bp head still 1", result_packed, {LN{16'd1}});
        ready_in = 1'b1;
        send(4'h3, 0, 0, "bp pass3");
        for (int n = 0; n < 4; n++) step("bp drain");
        check("bp empty", VW'(valid_out), VW'(0));

        // Full FIFO with simultaneous pop and offered beat: pop only
        ready_in = 1'b0;
        set_all(4, 0);
        send(4'h3, 0, 0, "full p1");
        set_all(5, 0);
        send(4'h3, 0, 0, "full p2");
        ready_in    = 1'b1;
        set_all(6, 0);
        instruction = {4'h3, 28'b0};
        valid_in    = 1'b1;
        step("full popedge");
        check("full popedge ready_out", VW'(ready_out), VW'(1));
        check("full popedge head", result_packed, {LN{16'd5}});
        send(4'h3, 0, 0, "full p3");
        for (int n = 0; n < 3; n++) step("full drain");

        // Non-MAC op during accumulation: error, ReLU still pushes, acc cleared
        set_all(5, 5);
        send(4'h1, 0, 0, "err mac");
        for (int i = 0; i < LN; i++) a_l[i] = (i % 2) ? DW'(7) : DW'(-4);
        send(4'h2, 0, 0, "err relu");
        check("err relu err_o", VW'(err_o), VW'(1));
        pat = '0;
        for (int i = 0; i < LN; i++) pat[i*DW +: DW] = (i % 2) ? 16'd7 : 16'd0;
        check("err relu value", result_packed, pat);
        step("err drain");
        set_all(1, 1);
        send(4'h1, 1, 0, "err mac1");
        check("err mac1 value", result_packed, {LN{16'd1}});
        step("err mac1 drain");

        // Asynchronous reset mid-accumulation with one FIFO entry
        ready_in = 1'b0;
        set_all(9, 9);
        send(4'h1, 1, 0, "rst fill");
        send(4'h1, 0, 0, "rst acc");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("async rst ready_out", VW'(ready_out), VW'(1));
        check("async rst valid_out", VW'(valid_out), VW'(0));
        check("async rst busy_o", VW'(busy_o), VW'(0));
        check("async rst err_o", VW'(err_o), VW'(0));
        check("async rst result", result_packed, '0);
        instruction = {4'h3, 28'b0};
        valid_in    = 1'b1;
        @(posedge clk);
        #1;
        check("rst no accept", VW'(valid_out), VW'(0));
        valid_in = 1'b0;
        rst      = 1'b0;
        ready_in = 1'b1;
        set_all(1, 1);
        send(4'h1, 1, 0, "post rst mac");
        check("post rst value", result_packed, {LN{16'd1}});
        step("post rst drain");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            int          pick;
            ins  = $urandom;
            pick = $urandom_range(0, 9);
            if (pick < 5)      ins[31:28] = 4'h1;
            else if (pick < 7) ins[31:28] = 4'h2;
            else if (pick < 9) ins[31:28] = 4'h3;
            if (ins[31:28] == 4'h1 && $urandom_range(0, 2) != 0) ins[27] = 1'b0;
            instruction = ins;
            for (int i = 0; i < LN; i++) begin
                a_l[i] = DW'($urandom);
                w_l[i] = DW'($urandom);
            end
            valid_in = ($urandom_range(0, 3) != 0);
            ready_in = ($urandom_range(0, 9) < 7);
            step("rand");
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        for (int n = 0; n < 4; n++) step("rand drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
